// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector
//
// Watches a registered serial bit stream that is qualified by a valid strobe.
// The last LEN valid bits are kept in a sliding window. Every occurrence of
// PATTERN is flagged, and overlapping occurrences count separately. Hits are
// tallied in a saturating counter. Every output comes straight from a flop.
//
// Parameters
//   LEN      window length in bits (2..16)
//   PATTERN  LEN-bit pattern; the MSB is the oldest bit and the LSB the newest
//   CNT_W    match counter width (1..16)
//
// Ports
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   din          serial data bit
//   din_valid    din is sampled only on edges where this is high
//   clear        synchronous clear of all state; has priority over din_valid
//   match        one-cycle registered pulse on a pattern hit
//   match_count  hits since reset/clear; saturates rather than wrapping
//   history      current window; bit 0 is the newest bit
//   fill_done    high once LEN valid bits have arrived since reset/clear

module serial_pattern_detector #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN-1:0]   history,
    output logic             fill_done
);

    localparam int               FW        = $clog2(LEN + 1);
    localparam logic [FW-1:0]    FILL_INIT = FW'(LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // The fill tracker is a down-counter. It holds the number of valid bits
    // still needed before the window is full, and it parks at zero.
    logic [FW-1:0]  fill_rem;

    logic [LEN-1:0] history_nxt;
    logic           fill_done_nxt;
    logic           hit;

    always_comb begin
        history_nxt   = {history[LEN-2:0], din};
        // The window is full after this bit when at most one bit was still
        // outstanding before it.
        fill_done_nxt = (fill_rem <= FW'(1));
        hit           = fill_done_nxt && (history_nxt == PATTERN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history     <= '0;
            fill_rem    <= FILL_INIT;
            fill_done   <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
        end else if (clear) begin
            history     <= '0;
            fill_rem    <= FILL_INIT;
            fill_done   <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
        end else if (din_valid) begin
            history   <= history_nxt;
            fill_done <= fill_done_nxt;
            match     <= hit;
            if (fill_rem != '0) begin
                fill_rem <= fill_rem - FW'(1);
            end
            if (hit && (match_count != CNT_MAX)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end else begin
            match <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_pattern_detector.sv
module tb_serial_pattern_detector;

    logic clk;
    logic rst_n;
    logic din;
    logic din_valid;
    logic clear;

    logic       m_a  [3];
    logic [3:0] h_a  [3];
    logic       f_a  [3];
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    // Instance 0: default configuration.
    serial_pattern_detector #(.LEN(4), .PATTERN(4'b1011), .CNT_W(8)) u_dflt (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear(clear),
        .match(m_a[0]), .match_count(cnt0), .history(h_a[0]), .fill_done(f_a[0])
    );

    // Instance 1: all-zero pattern, which exercises the fill guard.
    serial_pattern_detector #(.LEN(4), .PATTERN(4'b0000), .CNT_W(8)) u_zero (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear(clear),
        .match(m_a[1]), .match_count(cnt1), .history(h_a[1]), .fill_done(f_a[1])
    );

    // Instance 2: narrow counter, which exercises saturation.
    serial_pattern_detector #(.LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear(clear),
        .match(m_a[2]), .match_count(cnt2), .history(h_a[2]), .fill_done(f_a[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the valid bits received since reset/clear, trimmed to
    // the window length, plus running totals.
    bit       wq  [3][$];
    int       nb  [3];
    bit       mm  [3];
    int       mc  [3];
    int       cmax[3] = '{255, 255, 3};
    bit [3:0] pat [3] = '{4'b1011, 4'b0000, 4'b1011};

    function automatic int window_val(int k);
        int w = 0;
        for (int i = 0; i < wq[k].size(); i++) w = w * 2 + int'(wq[k][i]);
        return w;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            wq[k].delete();
            nb[k] = 0;
            mm[k] = 0;
            mc[k] = 0;
        end
    endfunction

    function automatic void model_step(bit c, bit v, bit d);
        for (int k = 0; k < 3; k++) begin
            if (c) begin
                wq[k].delete();
                nb[k] = 0;
                mm[k] = 0;
                mc[k] = 0;
            end else if (v) begin
                wq[k].push_back(d);
                if (wq[k].size() > 4) void'(wq[k].pop_front());
                nb[k] = nb[k] + 1;
                mm[k] = (nb[k] >= 4) && (window_val(k) == int'(pat[k]));
                if (mm[k] && mc[k] < cmax[k]) mc[k] = mc[k] + 1;
            end else begin
                mm[k] = 0;
            end
        end
    endfunction

    function automatic int get_cnt(int k);
        if (k == 0) return int'(cnt0);
        if (k == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_u%0d_match", tag, k), int'(m_a[k]), int'(mm[k]));
            chk($sformatf("%s_u%0d_hist", tag, k), int'(h_a[k]), window_val(k));
            chk($sformatf("%s_u%0d_fill", tag, k), int'(f_a[k]), int'(nb[k] >= 4));
            chk($sformatf("%s_u%0d_cnt", tag, k), get_cnt(k), mc[k]);
        end
    endtask

    // Inputs are driven 1 ns after a rising edge and sampled by the next edge.
    // Outputs are checked 1 ns after that edge.
    task automatic cycle(bit c, bit v, bit d, string tag);
        clear     = c;
        din_valid = v;
        din       = d;
        @(posedge clk);
        model_step(c, v, d);
        #1;
        check_model(tag);
    endtask

    task automatic drive_bits(int n, int unsigned bits, string tag);
        for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b1, bit'(bits >> i), tag);
    endtask

    typedef struct {
        bit       c;
        bit       v;
        bit       d;
        bit       m;
        bit [3:0] h;
        bit       f;
        int       n;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Expected values of the default instance after each edge.
        tbl.push_back('{0, 1, 1, 0, 4'b0001, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 4'b0010, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 4'b0101, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 4'b1011, 1, 1}); // basic hit
        tbl.push_back('{0, 1, 0, 0, 4'b0110, 1, 1});
        tbl.push_back('{0, 1, 1, 0, 4'b1101, 1, 1});
        tbl.push_back('{0, 1, 1, 1, 4'b1011, 1, 2}); // overlapping hit
        tbl.push_back('{0, 0, 1, 0, 4'b1011, 1, 2}); // idle edge
        tbl.push_back('{1, 1, 1, 0, 4'b0000, 0, 0}); // clear beats valid
        tbl.push_back('{0, 1, 1, 0, 4'b0001, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 4'b0010, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 4'b0010, 0, 0}); // gap
        tbl.push_back('{0, 0, 0, 0, 4'b0010, 0, 0}); // gap
        tbl.push_back('{0, 1, 1, 0, 4'b0101, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 4'b1011, 1, 1});

        rst_n     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        clear     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].c, tbl[i].v, tbl[i].d, $sformatf("tblm%0d", i));
            chk($sformatf("tbl%0d_match", i), int'(m_a[0]), int'(tbl[i].m));
            chk($sformatf("tbl%0d_hist", i), int'(h_a[0]), int'(tbl[i].h));
            chk($sformatf("tbl%0d_fill", i), int'(f_a[0]), int'(tbl[i].f));
            chk($sformatf("tbl%0d_cnt", i), int'(cnt0), tbl[i].n);
        end

        // Fill guard on the all-zero pattern instance.
        cycle(1'b1, 1'b0, 1'b0, "fg_clr");
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, "fg");
            chk($sformatf("fg_match%0d", i), int'(m_a[1]), int'(i >= 4));
            chk($sformatf("fg_cnt%0d", i), int'(cnt1), (i >= 4) ? i - 3 : 0);
        end

        // Five hits: the narrow counter saturates and the wide one keeps going.
        cycle(1'b1, 1'b0, 1'b0, "sat_clr");
        drive_bits(16, 16'b1011011011011011, "sat");
        chk("sat_cnt2", int'(cnt2), 3);
        chk("sat_cnt0", int'(cnt0), 5);
        drive_bits(2, 2'b10, "sat2");
        cycle(1'b1, 1'b1, 1'b1, "sat_clrv");
        drive_bits(2, 2'b11, "sat3");
        chk("clr_match", int'(m_a[2]), 0);
        chk("clr_hist", int'(h_a[2]), 4'b0011);
        chk("clr_fill", int'(f_a[2]), 0);
        chk("clr_cnt", int'(cnt2), 0);

        // Async reset mid-stream with three hits counted.
        cycle(1'b1, 1'b0, 1'b0, "ar_clr");
        drive_bits(10, 10'b1011011011, "ar");
        chk("ar_pre_cnt", int'(cnt0), 3);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_model("ar_async");
        chk("ar_async_cnt", int'(cnt0), 0);
        @(posedge clk);
        #1;
        check_model("ar_hold");
        rst_n = 1'b1;
        drive_bits(3, 3'b101, "ar_fill");
        chk("ar_fill3", int'(f_a[0]), 0);
        drive_bits(1, 1'b1, "ar_fill");
        chk("ar_fill4", int'(f_a[0]), 1);
        chk("ar_match4", int'(m_a[0]), 1);

        // Randomized stream with occasional clears.
        for (int i = 0; i < 2000; i++) begin
            cycle(bit'($urandom_range(0, 31) == 0), bit'($urandom_range(0, 3) != 0),
                  bit'($urandom_range(0, 1)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
